// File: rtl/varint_encoder_p.sv
// Protobuf-style varint (LEB128) encoder.
// Pops one value at a time from a first-word-fall-through FIFO, optionally
// zigzag-maps it, emits it as 7-bit groups (least significant first, bit 7
// set on every byte except the last) and then pushes the byte count and the
// field index to a separate metadata FIFO.
module varint_encoder_p #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_empty,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_zigzag,
  input  logic [IDX_W-1:0]  in_index,
  output logic              in_pop,
  input  logic              out_full,
  output logic              out_push,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              out_clr,
  input  logic              meta_full,
  output logic              meta_push,
  output logic [3:0]        meta_size,
  output logic [IDX_W-1:0]  meta_index,
  output logic              encoding
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ENCODE = 2'd2,
    META   = 2'd3
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [3:0]         count;
  logic [IDX_W-1:0]   index_q;
  logic [DATA_W-1:0]  zz_value;
  logic               more;

  // Zigzag maps small-magnitude signed values onto small unsigned codes:
  // shift left one place and flip every bit when the value is negative.
  assign zz_value = {in_data[DATA_W-2:0], 1'b0} ^ {DATA_W{in_data[DATA_W-1]}};

  // Any bit left above the current 7-bit group means another byte follows.
  assign more = |shreg[DATA_W-1:7];

  // Handshake strobes are the only outputs allowed to follow the FIFO flags.
  // out_clr is qualified by the reset pin so it stays low while reset is held
  // and pulses for the single INIT cycle that follows release.
  assign in_pop    = (state == IDLE)   && !in_empty;
  assign out_push  = (state == ENCODE) && !out_full;
  assign meta_push = (state == META)   && !meta_full;
  assign out_clr   = (state == INIT)   && reset;

  // Byte, last flag and metadata come straight from the state registers.
  assign out_data   = (state == ENCODE) ? {more, shreg[6:0]} : 8'h00;
  assign out_last   = (state == ENCODE) && !more;
  assign meta_size  = count;
  assign meta_index = index_q;

  // Main controller: capture on pop, shift out 7 bits per accepted byte,
  // then hand the byte count and index to the metadata FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      shreg    <= '0;
      count    <= '0;
      index_q  <= '0;
      encoding <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state <= IDLE;
        end
        IDLE: begin
          if (!in_empty) begin
            shreg    <= in_zigzag ? zz_value : in_data;
            index_q  <= in_index;
            count    <= '0;
            encoding <= 1'b1;
            state    <= ENCODE;
          end
        end
        ENCODE: begin
          if (!out_full) begin
            shreg <= shreg >> 7;
            count <= count + 4'd1;
            if (!more) begin
              state <= META;
            end
          end
        end
        META: begin
          if (!meta_full) begin
            count    <= '0;
            encoding <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_varint_encoder_p.sv
// Self-checking bench for varint_encoder_p: a 32-bit instance driven by a
// randomized FIFO source and checked every cycle against a queue-based
// varint model, plus a 64-bit instance exercised with directed and random
// values.
module tb_varint_encoder_p;

  localparam int W  = 32;
  localparam int IW = 8;

  typedef byte unsigned bq_t[$];

  typedef struct {
    logic [W-1:0]  d;
    bit            z;
    logic [IW-1:0] i;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          in_empty, in_zigzag, in_pop, out_full, out_push, out_last, out_clr;
  logic          meta_full, meta_push, encoding;
  logic [W-1:0]  in_data;
  logic [IW-1:0] in_index, meta_index;
  logic [7:0]    out_data;
  logic [3:0]    meta_size;

  logic          in_empty_w, in_zigzag_w, in_pop_w, out_full_w, out_push_w, out_last_w, out_clr_w;
  logic          meta_full_w, meta_push_w, encoding_w;
  logic [63:0]   in_data_w;
  logic [IW-1:0] in_index_w, meta_index_w;
  logic [7:0]    out_data_w;
  logic [3:0]    meta_size_w;

  varint_encoder_p #(.DATA_W(W), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .in_empty(in_empty), .in_data(in_data), .in_zigzag(in_zigzag), .in_index(in_index),
    .in_pop(in_pop), .out_full(out_full), .out_push(out_push), .out_data(out_data),
    .out_last(out_last), .out_clr(out_clr), .meta_full(meta_full), .meta_push(meta_push),
    .meta_size(meta_size), .meta_index(meta_index), .encoding(encoding)
  );

  varint_encoder_p #(.DATA_W(64), .IDX_W(IW)) dut64 (
    .clk(clk), .reset(reset),
    .in_empty(in_empty_w), .in_data(in_data_w), .in_zigzag(in_zigzag_w), .in_index(in_index_w),
    .in_pop(in_pop_w), .out_full(out_full_w), .out_push(out_push_w), .out_data(out_data_w),
    .out_last(out_last_w), .out_clr(out_clr_w), .meta_full(meta_full_w), .meta_push(meta_push_w),
    .meta_size(meta_size_w), .meta_index(meta_index_w), .encoding(encoding_w)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: zigzag as the integer mapping n>=0 -> 2n, n<0 -> -2n-1,
  // then little-endian base-128 groups with a continuation bit.
  function automatic bq_t encode_bytes(input logic [63:0] x, input bit zig, input int w);
    bq_t         q;
    logic [63:0] mask, v;
    longint      s;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    v = x & mask;
    if (zig) begin
      s = longint'(v << (64 - w)) >>> (64 - w);
      if (s >= 0) v = 64'(2 * s);
      else v = 64'(-2 * s - 1);
      v = v & mask;
    end
    q = {};
    do begin
      q.push_back({((v >> 7) != 0) ? 1'b1 : 1'b0, v[6:0]});
      v = v >> 7;
    end while (v != 0);
    return q;
  endfunction

  function automatic string qstr(input bq_t q);
    string s;
    s = "";
    foreach (q[k]) s = {s, $sformatf("%02h ", q[k])};
    return s;
  endfunction

  task automatic cmp_q(input string name, input bq_t got, input bq_t exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got bytes %s required %s", name, qstr(got), qstr(exp));
    end
  endtask

  // Scoreboard state shared between the source driver and the monitor.
  item_t          src_q[$];
  bq_t            exp_bytes;
  int             exp_size_q[$];
  logic [IW-1:0]  exp_idx_q[$];
  bq_t            byte_log;
  int             meta_log[$];
  bit             busy = 0;
  bit             popped = 0;
  int             pr = 0;
  int             clr_count = 0;
  int             empty_pct = 0, full_pct = 0, mfull_pct = 0;
  int             force_full = 0, force_mfull = 0;

  bq_t            mon_q;
  byte unsigned   mon_b;
  bit             exp_pop, exp_push, exp_mpush;

  // Per-cycle compare process for the 32-bit instance.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (in_pop || out_push || out_clr || meta_push || out_data != 8'h00 || out_last ||
          meta_size != 4'd0 || meta_index != '0 || encoding) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got pop=%0b push=%0b clr=%0b mpush=%0b data=%02h last=%0b size=%0d idx=%0d enc=%0b required all 0",
                 in_pop, out_push, out_clr, meta_push, out_data, out_last, meta_size, meta_index, encoding);
      end
      exp_bytes.delete();
      exp_size_q.delete();
      exp_idx_q.delete();
      busy   = 0;
      popped = 0;
      pr     = 0;
    end else begin
      checks++;
      if (out_clr !== (pr == 0)) begin
        errors++;
        $display("[TB] FAIL out_clr: got %0b required %0b", out_clr, (pr == 0));
      end
      if (out_clr) clr_count++;
      exp_pop   = !busy && !in_empty && (pr > 0);
      exp_push  = busy && (exp_bytes.size() > 0) && !out_full;
      exp_mpush = busy && (exp_bytes.size() == 0) && !meta_full;
      checks++;
      if ({in_pop, out_push, meta_push, encoding} !== {exp_pop, exp_push, exp_mpush, busy}) begin
        errors++;
        $display("[TB] FAIL strobes: got pop/push/mpush/enc=%b%b%b%b required %b%b%b%b",
                 in_pop, out_push, meta_push, encoding, exp_pop, exp_push, exp_mpush, busy);
      end
      if (pr < 2) pr++;
      if (out_push && exp_bytes.size() > 0) begin
        mon_b = exp_bytes.pop_front();
        checks++;
        if (out_data !== mon_b || out_last !== (exp_bytes.size() == 0)) begin
          errors++;
          $display("[TB] FAIL byte: got data=%02h last=%0b required data=%02h last=%0b",
                   out_data, out_last, mon_b, (exp_bytes.size() == 0));
        end
        byte_log.push_back(out_data);
      end
      if (meta_push && exp_size_q.size() > 0) begin
        checks++;
        if (meta_size !== 4'(exp_size_q[0]) || meta_index !== exp_idx_q[0]) begin
          errors++;
          $display("[TB] FAIL meta: got size=%0d idx=%0d required size=%0d idx=%0d",
                   meta_size, meta_index, exp_size_q[0], exp_idx_q[0]);
        end
        void'(exp_size_q.pop_front());
        void'(exp_idx_q.pop_front());
        meta_log.push_back(int'(meta_size));
        busy = 0;
      end
      if (in_pop) begin
        mon_q = encode_bytes(64'(in_data), in_zigzag, W);
        foreach (mon_q[k]) exp_bytes.push_back(mon_q[k]);
        exp_size_q.push_back(mon_q.size());
        exp_idx_q.push_back(in_index);
        busy   = 1;
        popped = 1;
      end
    end
  end

  // One clock of FIFO-source behaviour: drop the popped head, present the
  // next item (or garbage while empty) and apply back-pressure.
  task automatic applyStimulusCycle();
    @(posedge clk);
    #1;
    if (popped) begin
      popped = 0;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (src_q.size() > 0 && $urandom_range(0, 99) >= empty_pct) begin
      in_empty  = 1'b0;
      in_data   = src_q[0].d;
      in_zigzag = src_q[0].z;
      in_index  = src_q[0].i;
    end else begin
      in_empty  = 1'b1;
      in_data   = $urandom;
      in_zigzag = 1'($urandom_range(0, 1));
      in_index  = 8'($urandom);
    end
    out_full  = (force_full > 0) ? 1'b1 : ($urandom_range(0, 99) < full_pct);
    meta_full = (force_mfull > 0) ? 1'b1 : ($urandom_range(0, 99) < mfull_pct);
    if (force_full > 0) force_full--;
    if (force_mfull > 0) force_mfull--;
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n_items, input int budget);
    int c;
    logic [63:0] r;
    item_t it;
    for (int k = 0; k < n_items; k++) begin
      r = {$urandom, $urandom} >> $urandom_range(0, 63);
      it.d = r[W-1:0];
      it.z = 1'($urandom_range(0, 1));
      it.i = 8'($urandom);
      src_q.push_back(it);
    end
    c = 0;
    while ((src_q.size() > 0 || busy) && c < budget) begin
      applyStimulusCycle();
      c++;
    end
    checks++;
    if (src_q.size() > 0 || busy) begin
      errors++;
      $display("[TB] FAIL random_drain: got %0d items left busy=%0b required 0 left", src_q.size(), busy);
    end
  endtask

  task automatic push_item(input logic [W-1:0] d, input bit z, input logic [IW-1:0] i);
    item_t it;
    it.d = d;
    it.z = z;
    it.i = i;
    src_q.push_back(it);
  endtask

  task automatic clear_logs();
    byte_log.delete();
    meta_log.delete();
  endtask

  task automatic wait_meta(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (meta_log.size() < n && c < budget) begin
      applyStimulusCycle();
      c++;
    end
    checks++;
    if (meta_log.size() < n) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d meta pushes required %0d", name, meta_log.size(), n);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (byte_log.size() < n && c < budget) begin
      applyStimulusCycle();
      c++;
    end
    checks++;
    if (byte_log.size() < n) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d bytes required %0d", name, byte_log.size(), n);
    end
  endtask

  task automatic checkOutput(input string name, input bq_t exp);
    cmp_q(name, byte_log, exp);
    checks++;
    if (meta_log.size() == 0 || meta_log[0] != exp.size()) begin
      errors++;
      $display("[TB] FAIL %s_size: got %0d required %0d", name,
               (meta_log.size() == 0) ? -1 : meta_log[0], exp.size());
    end
  endtask

  // Drive one value into the 64-bit instance and collect what it emits.
  task automatic run64(input logic [63:0] d, input bit z, input logic [IW-1:0] idx,
                       output bq_t got, output int sz);
    bq_t gq;
    bit  pw;
    int  n;
    gq = {};
    sz = 0;
    pw = 0;
    n  = 0;
    @(posedge clk);
    #1;
    in_empty_w = 1'b0; in_data_w = d; in_zigzag_w = z; in_index_w = idx;
    while (sz == 0 && n < 40) begin
      @(negedge clk);
      if (in_pop_w) pw = 1;
      if (out_push_w) begin
        gq.push_back(out_data_w);
        checks++;
        if (!encoding_w || out_clr_w || out_last_w !== (out_data_w[7] == 1'b0)) begin
          errors++;
          $display("[TB] FAIL w64_byte_flags: got enc=%0b clr=%0b last=%0b data=%02h required enc=1 clr=0 last=~data[7]",
                   encoding_w, out_clr_w, out_last_w, out_data_w);
        end
      end
      if (meta_push_w) begin
        sz = int'(meta_size_w);
        checks++;
        if (meta_index_w !== idx) begin
          errors++;
          $display("[TB] FAIL w64_index: got %0d required %0d", meta_index_w, idx);
        end
      end
      @(posedge clk);
      #1;
      if (pw) begin
        pw = 0;
        in_empty_w = 1'b1;
        in_data_w  = {$urandom, $urandom};
      end
      n++;
    end
    in_empty_w = 1'b1;
    got = gq;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bq_t e, g;
    int  sz, n, clr_before;
    logic [63:0] r;
    bit  zz;

    reset = 1'b0;
    in_empty = 1'b1; in_data = '0; in_zigzag = 1'b0; in_index = '0;
    out_full = 1'b0; meta_full = 1'b0;
    in_empty_w = 1'b1; in_data_w = '0; in_zigzag_w = 1'b0; in_index_w = '0;
    out_full_w = 1'b0; meta_full_w = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Hand-computed encodings pin the model itself.
    e = '{8'h8A, 8'h9F, 8'hD2, 8'hF5, 8'h0A};
    cmp_q("model_aeb48f8a", encode_bytes(64'hAEB48F8A, 0, 32), e);
    e = '{8'h01};
    cmp_q("model_zz_m1", encode_bytes(64'hFFFFFFFF, 1, 32), e);
    e = '{8'h02};
    cmp_q("model_zz_p1", encode_bytes(64'h1, 1, 32), e);
    e = '{8'h00};
    cmp_q("model_zero", encode_bytes(64'h0, 0, 32), e);
    e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    cmp_q("model_w64_ones", encode_bytes({64{1'b1}}, 0, 64), e);

    repeat (3) applyStimulusCycle();

    // Multi-byte value, no stalls.
    clear_logs();
    push_item(32'hAEB48F8A, 0, 8'd3);
    wait_meta(1, 50, "aeb48f8a");
    e = '{8'h8A, 8'h9F, 8'hD2, 8'hF5, 8'h0A};
    checkOutput("aeb48f8a", e);

    // Output back-pressure after the first byte while new input waits.
    clear_logs();
    push_item(32'h81, 0, 8'd5);
    push_item(32'h12345, 0, 8'd7);
    wait_bytes(1, 50, "stall81");
    force_full = 2;
    wait_meta(1, 50, "stall81");
    e = '{8'h81, 8'h01};
    checkOutput("stall81", e);
    wait_meta(2, 50, "stall81_next");

    // Zigzag values.
    clear_logs();
    push_item(32'hFFFFFFFF, 1, 8'd1);
    wait_meta(1, 50, "zz_m1");
    e = '{8'h01};
    checkOutput("zz_m1", e);
    clear_logs();
    push_item(32'h1, 1, 8'd2);
    wait_meta(1, 50, "zz_p1");
    e = '{8'h02};
    checkOutput("zz_p1", e);
    clear_logs();
    push_item(32'h0, 1, 8'd4);
    wait_meta(1, 50, "zz_zero");
    e = '{8'h00};
    checkOutput("zz_zero", e);

    // Metadata back-pressure with input waiting.
    clear_logs();
    push_item(32'h300, 0, 8'd9);
    push_item(32'h5, 0, 8'd10);
    wait_bytes(2, 50, "meta_stall");
    force_mfull = 3;
    n = 0;
    while (meta_log.size() < 1 && n < 20) begin
      applyStimulusCycle();
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL meta_stall_cycles: got %0d required 4", n);
    end
    e = '{8'h80, 8'h06};
    checkOutput("meta_stall", e);
    wait_meta(2, 50, "meta_stall_next");

    // Reset in the middle of a value.
    clear_logs();
    push_item(32'hAEB48F8A, 0, 8'd11);
    wait_bytes(2, 50, "reset_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    src_q.delete();
    popped = 0;
    in_empty = 1'b1;
    repeat (3) @(negedge clk);
    clr_before = clr_count;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) applyStimulusCycle();
    checks++;
    if (byte_log.size() != 2 || clr_count - clr_before != 1) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %0d bytes %0d clr pulses required 2 bytes 1 clr pulse",
               byte_log.size(), clr_count - clr_before);
    end
    clear_logs();
    push_item(32'h7F, 0, 8'd12);
    wait_meta(1, 50, "after_reset");
    e = '{8'h7F};
    checkOutput("after_reset", e);

    // Randomized traffic: first without stalls, then with all back-pressure.
    applyStimulus(60, 3000);
    empty_pct = 30; full_pct = 25; mfull_pct = 20;
    applyStimulus(300, 20000);
    empty_pct = 0; full_pct = 0; mfull_pct = 0;

    // 64-bit instance.
    run64({64{1'b1}}, 0, 8'd21, g, sz);
    e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    cmp_q("w64_ones", g, e);
    checks++;
    if (sz != 10) begin
      errors++;
      $display("[TB] FAIL w64_ones_size: got %0d required 10", sz);
    end
    for (int k = 0; k < 20; k++) begin
      r  = {$urandom, $urandom} >> $urandom_range(0, 63);
      zz = 1'($urandom_range(0, 1));
      run64(r, zz, 8'(k), g, sz);
      e = encode_bytes(r, zz, 64);
      cmp_q($sformatf("w64_rand%0d", k), g, e);
      checks++;
      if (sz != e.size()) begin
        errors++;
        $display("[TB] FAIL w64_rand%0d_size: got %0d required %0d", k, sz, e.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/varint_encoder_p.md
VARINT_ENCODER_P -- requirements
Module: varint_encoder_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning input value width; legal range 8..64.
REQ-002 SHALL have parameter IDX_W, default 8, meaning field-index width carried alongside each value.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_empty  input  1  input FIFO empty; first-word-fall-through, so in_data, in_zigzag and in_index are valid while low.
REQ-006 SHALL have port in_data  input  DATA_W  unsigned value, or two's-complement value when in_zigzag=1.
REQ-007 SHALL have port in_zigzag  input  1  per-value zigzag (sint) mode select.
REQ-008 SHALL have port in_index  input  IDX_W  protobuf field index of the value.
REQ-009 SHALL have port in_pop  output  1  one-cycle pop of the input FIFO.
REQ-010 SHALL have port out_full  input  1  byte FIFO full.
REQ-011 SHALL have port out_push  output  1  byte FIFO push strobe.
REQ-012 SHALL have port out_data  output  8  encoded byte.
REQ-013 SHALL have port out_last  output  1  high with the final byte of a value.
REQ-014 SHALL have port out_clr  output  1  downstream FIFO clear pulse.
REQ-015 SHALL have port meta_full  input  1  size/index FIFO full.
REQ-016 SHALL have port meta_push  output  1  size/index FIFO push strobe.
REQ-017 SHALL have port meta_size  output  4  encoded byte count, 1..ceil(DATA_W/7).
REQ-018 SHALL have port meta_index  output  IDX_W  field index of the encoded value.
REQ-019 SHALL have port encoding  output  1  high while a value is held (ENCODE or META state).

Function
REQ-020 SHALL implement states INIT, IDLE, ENCODE, META.
REQ-021 INIT SHALL assert out_clr for exactly one cycle, then go to IDLE unconditionally.
REQ-022 In IDLE with in_empty=0, the block SHALL assert in_pop combinationally, register the value, index and mode on that clock edge, and go to ENCODE; with in_empty=1 it SHALL stay in IDLE with in_pop=0.
REQ-023 Zigzag mode SHALL register (x<<1) XOR (x arithmetic-shifted right by DATA_W-1), truncated to DATA_W bits.
REQ-024 Non-zigzag mode SHALL register x unchanged.
REQ-025 In ENCODE with out_full=0, the block SHALL assert out_push.
  - out_data[6:0] = shreg[6:0].
  - out_data[7] = OR of the remaining bits shreg[DATA_W-1:7].
  - On the edge: shreg shifts right by 7 and the byte count increments.
REQ-026 The byte with out_data[7]=0 SHALL have out_last=1, and the state SHALL go to META on that edge.
REQ-027 In ENCODE with out_full=1: out_push=0, shreg and count hold, no byte lost or duplicated; resume on the first cycle out_full=0.
REQ-028 A value of 0 SHALL encode as the single byte 0x00, with meta_size=1.
REQ-029 In META with meta_full=0, the block SHALL assert meta_push with meta_size=count and meta_index=captured index, clear count, and go to IDLE; with meta_full=1 it SHALL hold in META.
REQ-030 Latency for an N-byte value with no stalls: pop at cycle 0, bytes at cycles 1..N, meta_push at cycle N+1, next pop no earlier than cycle N+2.
REQ-031 Changes on in_data, in_zigzag or in_index after the pop SHALL NOT affect the value in progress.
REQ-032 out_data, out_last, meta_size, meta_index and encoding SHALL be driven only from registers; only the push/pop strobes may depend combinationally on the full/empty inputs.

Reset
REQ-033 Reset asserted SHALL force state INIT, shreg=0 and count=0.
REQ-034 While reset is asserted, all strobes, out_data, out_last, meta_size, meta_index and encoding SHALL be 0.
REQ-035 Reset mid-value SHALL abort the value with no further pushes; the out_clr pulse in INIT SHALL flush the partial bytes downstream.

Verification
REQ-036 DATA_W=32, value 0xAEB48F8A, zigzag=0 -> bytes 8A 9F D2 F5 0A, out_last on 0A, meta_size=5.
REQ-037 Value 0x81, with out_full raised for 2 cycles after byte 81 and in_data changed during the stall -> bytes 81 01, meta_size=2.
REQ-038 Zigzag=1: value 0xFFFFFFFF (-1) -> byte 01; value 0x00000001 -> byte 02; value 0 -> byte 00; each meta_size=1.
REQ-039 DATA_W=64, value 0xFFFFFFFFFFFFFFFF -> nine bytes FF, then 01, meta_size=10.
REQ-040 meta_full held high 3 cycles after the last byte, with in_empty=0 -> no in_pop until meta_push completes.
REQ-041 Reset asserted after byte 2 of 0xAEB48F8A -> no more pushes, then a one-cycle out_clr pulse after release, then IDLE.
